// File: rtl/cluster_pwr_seq_pkg.sv
// rtl/cluster_pwr_seq_pkg.sv - shared states, defaults and output table for the cluster power sequencer
package cluster_pwr_seq_pkg;

  localparam int CNT_W               = 16;
  localparam int DEF_PWR_WAIT_CYCLES = 16;
  localparam int DEF_RST_WAIT_CYCLES = 8;
  localparam int DEF_DRAIN_TIMEOUT   = 1024;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PWR_UP  = 3'd1,
    ST_CLK_ON  = 3'd2,
    ST_RST_REL = 3'd3,
    ST_RUN     = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_PWR_DN  = 3'd6
  } state_e;

  typedef struct packed {
    logic pow;
    logic byp;
    logic rstn;
    logic fetch;
    logic clk_en;
  } ctl_t;

  // Cluster control levels held while in each state.
  function automatic ctl_t state_ctl(state_e s);
    ctl_t c;
    c = '{pow: 1'b0, byp: 1'b1, rstn: 1'b0, fetch: 1'b0, clk_en: 1'b0};
    case (s)
      ST_PWR_UP, ST_PWR_DN: c.pow = 1'b1;
      ST_CLK_ON: begin
        c.pow    = 1'b1;
        c.byp    = 1'b0;
        c.clk_en = 1'b1;
      end
      ST_RST_REL, ST_DRAIN: begin
        c.pow    = 1'b1;
        c.byp    = 1'b0;
        c.clk_en = 1'b1;
        c.rstn   = 1'b1;
      end
      ST_RUN: begin
        c.pow    = 1'b1;
        c.byp    = 1'b0;
        c.clk_en = 1'b1;
        c.rstn   = 1'b1;
        c.fetch  = 1'b1;
      end
      default: c = '{pow: 1'b0, byp: 1'b1, rstn: 1'b0, fetch: 1'b0, clk_en: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cluster_pwr_seq_if.sv
// rtl/cluster_pwr_seq_if.sv - request and cluster-control signal bundle of the power sequencer
interface cluster_pwr_seq_if;

  logic        req_on_i;
  logic        req_off_i;
  logic [63:0] boot_addr_i;
  logic        cluster_busy_i;

  logic        cluster_pow_o;
  logic        cluster_byp_o;
  logic        cluster_rstn_o;
  logic        cluster_fetch_enable_o;
  logic        cluster_clk_en_o;
  logic [63:0] cluster_boot_addr_o;
  logic        ack_o;
  logic [2:0]  state_o;
  logic        err_o;

  modport master (
    output req_on_i, req_off_i, boot_addr_i, cluster_busy_i,
    input  cluster_pow_o, cluster_byp_o, cluster_rstn_o, cluster_fetch_enable_o,
    input  cluster_clk_en_o, cluster_boot_addr_o, ack_o, state_o, err_o
  );

  modport slave (
    input  req_on_i, req_off_i, boot_addr_i, cluster_busy_i,
    output cluster_pow_o, cluster_byp_o, cluster_rstn_o, cluster_fetch_enable_o,
    output cluster_clk_en_o, cluster_boot_addr_o, ack_o, state_o, err_o
  );

endinterface

// File: rtl/cluster_pwr_seq_cnt.sv
// rtl/cluster_pwr_seq_cnt.sv - loadable wait down-counter; saturates at zero, done while count is one
module cluster_pwr_seq_cnt
  import cluster_pwr_seq_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/cluster_pwr_seq.sv
// rtl/cluster_pwr_seq.sv - cluster power-up/power-down sequencer FSM
// Optional DRAIN timeout with sticky err_o when CLUSTER_PWR_SEQ_TIMEOUT_EN is defined.
module cluster_pwr_seq
  import cluster_pwr_seq_pkg::*;
#(
  parameter int PWR_WAIT_CYCLES = DEF_PWR_WAIT_CYCLES,
  parameter int RST_WAIT_CYCLES = DEF_RST_WAIT_CYCLES,
  parameter int DRAIN_TIMEOUT   = DEF_DRAIN_TIMEOUT
) (
  input logic              clk_i,
  input logic              rst_i,
  cluster_pwr_seq_if.slave bus
);

  state_e           state_q;
  state_e           state_d;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_done;
  logic [CNT_W-1:0] cnt_load_val;
  ctl_t             ctl_q;
  logic             ack_q;
  logic [63:0]      addr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // A started power-up always runs to RUN; off wins over on only while in OFF.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OFF:     if (bus.req_on_i && !bus.req_off_i) state_d = ST_PWR_UP;
      ST_PWR_UP:  if (cnt_done) state_d = ST_CLK_ON;
      ST_CLK_ON:  state_d = ST_RST_REL;
      ST_RST_REL: if (cnt_done) state_d = ST_RUN;
      ST_RUN:     if (bus.req_off_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!bus.cluster_busy_i) state_d = ST_PWR_DN;
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
        else if (cnt_done) state_d = ST_PWR_DN;
`endif
      end
      ST_PWR_DN:  state_d = ST_OFF;
      default:    state_d = ST_OFF;
    endcase
  end

  // Counter is reloaded on every state change so each timed state starts fresh.
  always_comb begin
    cnt_load_val = '0;
    case (state_d)
      ST_PWR_UP:  cnt_load_val = CNT_W'(PWR_WAIT_CYCLES);
      ST_RST_REL: cnt_load_val = CNT_W'(RST_WAIT_CYCLES);
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
      ST_DRAIN:   cnt_load_val = CNT_W'(DRAIN_TIMEOUT);
`endif
      default:    cnt_load_val = '0;
    endcase
  end

  assign cnt_load = (state_d != state_q);
  assign cnt_en   = (state_q == ST_PWR_UP) || (state_q == ST_RST_REL) || (state_q == ST_DRAIN);

  cluster_pwr_seq_cnt u_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_load_val),
    .done     (cnt_done)
  );

  // Outputs are registered from the next state so they move with state_q.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctl_q  <= state_ctl(ST_OFF);
      ack_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      ctl_q <= state_ctl(state_d);
      ack_q <= ((state_q == ST_RST_REL) && (state_d == ST_RUN)) ||
               ((state_q == ST_PWR_DN) && (state_d == ST_OFF));
      if (state_d == ST_CLK_ON) begin
        addr_q <= bus.boot_addr_i;
      end
    end
  end

`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
  logic timeout_exit;
  logic err_q;

  assign timeout_exit = (state_q == ST_DRAIN) && bus.cluster_busy_i && cnt_done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (timeout_exit) begin
      err_q <= 1'b1;
    end else if ((state_d == ST_PWR_UP) && (state_q != ST_PWR_UP)) begin
      err_q <= 1'b0;
    end
  end

  assign bus.err_o = err_q;
`else
  // DRAIN_TIMEOUT only matters when the timeout is built in.
  logic unused_drain_timeout;
  assign unused_drain_timeout = ^DRAIN_TIMEOUT;
  assign bus.err_o = 1'b0;
`endif

  assign bus.cluster_pow_o          = ctl_q.pow;
  assign bus.cluster_byp_o          = ctl_q.byp;
  assign bus.cluster_rstn_o         = ctl_q.rstn;
  assign bus.cluster_fetch_enable_o = ctl_q.fetch;
  assign bus.cluster_clk_en_o       = ctl_q.clk_en;
  assign bus.cluster_boot_addr_o    = addr_q;
  assign bus.ack_o                  = ack_q;
  assign bus.state_o                = state_q;

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// tb/tb_cluster_pwr_seq.sv - randomized scoreboard bench for cluster_pwr_seq
`timescale 1ns/1ps
module tb_cluster_pwr_seq;

  localparam int PW = 4;
  localparam int RW = 2;
  localparam int TO = 10;
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [2:0] S_OFF = 3'd0, S_PWR_UP = 3'd1, S_CLK_ON = 3'd2, S_RST_REL = 3'd3;
  localparam logic [2:0] S_RUN = 3'd4, S_DRAIN = 3'd5, S_PWR_DN = 3'd6;

  typedef struct {
    int          cyc;
    logic [2:0]  st;
    logic [63:0] addr;
    logic        ack;
    logic        err;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [2:0]  st;
    logic [63:0] addr;
  } ack_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t        exp_q[$];
  ack_t        ack_q[$];
  logic [63:0] m_addr = '0;
  logic        m_err = 1'b0;

  cluster_pwr_seq_if bus();

  cluster_pwr_seq #(
    .PWR_WAIT_CYCLES (PW),
    .RST_WAIT_CYCLES (RW),
    .DRAIN_TIMEOUT   (TO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, req);
    end
  endfunction

  // {pow, byp, rstn, fetch, clk_en} required in each state.
  function automatic logic [4:0] exp_ctl(input logic [2:0] st);
    case (st)
      S_PWR_UP:  return 5'b11000;
      S_CLK_ON:  return 5'b10001;
      S_RST_REL: return 5'b10101;
      S_RUN:     return 5'b10111;
      S_DRAIN:   return 5'b10101;
      S_PWR_DN:  return 5'b11000;
      default:   return 5'b01000;
    endcase
  endfunction

  // Position k cycles after the edge that accepted req_on.
  function automatic logic [2:0] up_state(input int k);
    if (k <= PW) return S_PWR_UP;
    else if (k == PW + 1) return S_CLK_ON;
    else if (k <= PW + 1 + RW) return S_RST_REL;
    else return S_RUN;
  endfunction

  function automatic void exp_at(input int c, input logic [2:0] st, input logic ack);
    exp_q.push_back('{cyc: c, st: st, addr: m_addr, ack: ack, err: m_err});
  endfunction

  always @(negedge clk) begin
    exp_t e;
    ack_t a;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      check("missed_slot", cyc, e.cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check("state", bus.state_o, e.st);
      check("ctl", {bus.cluster_pow_o, bus.cluster_byp_o, bus.cluster_rstn_o,
                    bus.cluster_fetch_enable_o, bus.cluster_clk_en_o}, exp_ctl(e.st));
      check("ack", bus.ack_o, e.ack);
      check("err", bus.err_o, e.err);
      check("boot_addr", bus.cluster_boot_addr_o, e.addr);
    end
    if (bus.ack_o === 1'b1) begin
      if (ack_q.size() == 0) begin
        check("unexpected_ack", bus.ack_o, 1'b0);
      end else begin
        a = ack_q.pop_front();
        check("ack_cycle", cyc, a.cyc);
        check("ack_state", bus.state_o, a.st);
        check("ack_boot_addr", bus.cluster_boot_addr_o, a.addr);
      end
    end
  end

  // noise: 0 no req_off, 1 random req_off, 2 req_off held high during the sequence.
  task automatic power_up(input logic [63:0] addr, input int noise, input int rst_at);
    int b, hold, last;
    b    = cyc;
    hold = (rst_at != 0) ? 1 : $urandom_range(1, PW + RW + 2);
    last = (rst_at != 0) ? rst_at : PW + RW + 2;
    bus.boot_addr_i = addr;
    bus.req_on_i    = 1'b1;
    bus.req_off_i   = 1'b0;
    m_err = 1'b0;
    for (int k = 1; k <= last; k++) begin
      if (k == PW + 1) m_addr = addr;
      exp_at(b + k, up_state(k), k == PW + RW + 2);
    end
    if (rst_at != 0) begin
      m_addr = '0;
      m_err  = 1'b0;
      exp_at(b + rst_at + 1, S_OFF, 1'b0);
    end else begin
      ack_q.push_back('{cyc: b + PW + RW + 2, st: S_RUN, addr: addr});
    end
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == hold) bus.req_on_i = 1'b0;
      if (k <= PW + RW + 1 && noise == 1) bus.req_off_i = 1'($urandom_range(0, 1));
      else if (k <= PW + RW + 1 && noise == 2) bus.req_off_i = 1'b1;
      else bus.req_off_i = 1'b0;
      if (k >= PW + 2) bus.boot_addr_i = {$urandom, $urandom};
      if (k == rst_at) rst = 1'b1;
    end
    if (rst_at != 0) begin
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  task automatic power_down(input int dwell, input int busyc);
    int b, x, last;
    bit timeout;
    b = cyc;
    for (int k = 1; k <= dwell; k++) exp_at(b + k, S_RUN, 1'b0);
    repeat (dwell) @(negedge clk);
    b = cyc;
    bus.req_off_i      = 1'b1;
    bus.cluster_busy_i = 1'b1;
    bus.req_on_i       = 1'($urandom_range(0, 1));
    timeout = TO_EN && (busyc > TO);
    x    = timeout ? TO : busyc;
    last = ((busyc > x + 2) ? busyc : x + 2) + 1;
    for (int k = 1; k <= x; k++) exp_at(b + k, S_DRAIN, 1'b0);
    if (timeout) m_err = 1'b1;
    exp_at(b + x + 1, S_PWR_DN, 1'b0);
    exp_at(b + x + 2, S_OFF, 1'b1);
    for (int k = x + 3; k <= last; k++) exp_at(b + k, S_OFF, 1'b0);
    ack_q.push_back('{cyc: b + x + 2, st: S_OFF, addr: m_addr});
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == busyc) bus.cluster_busy_i = 1'b0;
    end
    bus.req_off_i = 1'b0;
    bus.req_on_i  = 1'b0;
  endtask

  task automatic contention(input int n);
    int b;
    b = cyc;
    bus.req_on_i  = 1'b1;
    bus.req_off_i = 1'b1;
    for (int k = 1; k <= n; k++) exp_at(b + k, S_OFF, 1'b0);
    repeat (n) @(negedge clk);
    bus.req_on_i  = 1'b0;
    bus.req_off_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    bus.req_on_i       = 1'b0;
    bus.req_off_i      = 1'b0;
    bus.boot_addr_i    = '0;
    bus.cluster_busy_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    b = cyc;
    exp_at(b + 1, S_OFF, 1'b0);
    exp_at(b + 2, S_OFF, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    b = cyc;
    for (int k = 1; k <= 3; k++) exp_at(b + k, S_OFF, 1'b0);
    repeat (3) @(negedge clk);

    contention(20);
    power_up(64'h0000_0000_1C00_8080, 0, 0);
    power_down(0, 5);
    power_up({$urandom, $urandom}, 2, 0);
    power_down(2, 1);

    repeat (4) begin
      power_up({$urandom, $urandom}, 1, 0);
      power_down($urandom_range(0, 5), $urandom_range(1, 6));
    end

    power_up({$urandom, $urandom}, 0, 0);
    power_down(1, TO_EN ? 15 : 1000);
    power_up({$urandom, $urandom}, 0, 0);
    power_down(0, 2);

    power_up({$urandom, $urandom}, 0, PW + RW);
    contention(3);

    @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
